// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared external combinational ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP and its result returns only to the issuer.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_c,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_c,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_c,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic              rr_last_reg;
    logic              owner_reg;
    logic [DATA_W-1:0] alu_a_reg, alu_b_reg, result_reg;
    logic [OP_W-1:0]   alu_op_reg;
    logic              grant;
    logic              accept;
    logic [1:0]        rsp_ready_vec;
    logic [1:0]        rsp_valid_vec;
    logic [DATA_W-1:0] rsp_c_arr [2];

    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

    // With both valid, the requester not served last wins; otherwise the lone valid one.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~rr_last_reg;
        end
        // Ready is masked while rst is held so outputs read zero during reset.
        accept = (state_reg == IDLE) && (req0_valid || req1_valid) && !rst;
    end

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready_vec[owner_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_last_reg <= 1'b1;
            owner_reg   <= 1'b0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_op_reg  <= '0;
            result_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                alu_a_reg   <= grant ? req1_a  : req0_a;
                alu_b_reg   <= grant ? req1_b  : req0_b;
                alu_op_reg  <= grant ? req1_op : req0_op;
                owner_reg   <= grant;
                rr_last_reg <= grant;
            end
            if (state_reg == EXEC) begin
                result_reg <= alu_c;
            end
        end
    end

    // Result is steered to the owner only; the idle channel reads zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_valid_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
            assign rsp_c_arr[gi]     = rsp_valid_vec[gi] ? result_reg : '0;
        end
    endgenerate

    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_c     = rsp_c_arr[0];
    assign rsp1_c     = rsp_c_arr[1];
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_op     = alu_op_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random bench for alu_arbiter with a behavioural ALU and
// per-requester result queues filled at request handshake, drained at response handshake.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_c, rsp1_c;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .OP_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .busy(busy)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return ~a;
        endcase
    endfunction

    assign alu_c = alu_f(alu_a, alu_b, alu_op);

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard plus per-cycle protocol invariants, sampled mid-cycle.
    logic        pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;
    logic [31:0] pc0 = 0, pc1 = 0;
    always @(negedge clk) begin
        if (rst) begin
            pv0 = 0;
            pv1 = 0;
        end else begin
            chk1("ready_onehot", req0_ready & req1_ready, 1'b0);
            chk1("ready_when_busy", busy & (req0_ready | req1_ready), 1'b0);
            chk1("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
            if (!rsp0_valid) chkw("rsp0_c_idle", rsp0_c, 32'd0);
            if (!rsp1_valid) chkw("rsp1_c_idle", rsp1_c, 32'd0);
            if (pv0 && !pr0) begin
                chk1("hold_v0", rsp0_valid, 1'b1);
                chkw("hold_c0", rsp0_c, pc0);
            end
            if (pv1 && !pr1) begin
                chk1("hold_v1", rsp1_valid, 1'b1);
                chkw("hold_c1", rsp1_c, pc1);
            end
            if (req0_valid && req0_ready) q0.push_back(alu_f(req0_a, req0_b, req0_op));
            if (req1_valid && req1_ready) q1.push_back(alu_f(req1_a, req1_b, req1_op));
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) chkw("sb_rsp0_pending", 32'(q0.size()), 32'd1);
                else chkw("sb_rsp0", rsp0_c, q0.pop_front());
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) chkw("sb_rsp1_pending", 32'(q1.size()), 32'd1);
                else chkw("sb_rsp1", rsp1_c, q1.pop_front());
            end
            pv0 = rsp0_valid; pr0 = rsp0_ready; pc0 = rsp0_c;
            pv1 = rsp1_valid; pr1 = rsp1_ready; pc1 = rsp1_c;
        end
    end

    logic [31:0] t2_exp [4] = '{32'd7, 32'hFF, 32'd16, 32'h3C};
    int  ops, ncyc;
    bit  hs0, hs1;

    initial begin
        rst = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (2) cyc();
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
        chkw("rst_alu_a", alu_a, 32'd0);
        cyc();
        rst = 0;

        // 1: lone req0 add, two-cycle latency
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 3'd0; rsp0_ready = 1; rsp1_ready = 1;
        @(negedge clk);
        chk1("t1_req0_ready", req0_ready, 1'b1);
        chk1("t1_req1_ready", req1_ready, 1'b0);
        cyc();
        req0_valid = 0;
        @(negedge clk);
        chk1("t1_busy_exec", busy, 1'b1);
        chkw("t1_alu_a", alu_a, 32'd5);
        chkw("t1_alu_b", alu_b, 32'd7);
        chk1("t1_no_rsp_exec", rsp0_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk1("t1_rsp0_valid", rsp0_valid, 1'b1);
        chkw("t1_rsp0_c", rsp0_c, 32'd12);
        chk1("t1_rsp1_valid", rsp1_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk1("t1_idle_busy", busy, 1'b0);
        chkw("t1_alu_a_kept", alu_a, 32'd5);

        // 2: both valid after reset, grants alternate 0,1,0,1
        rst = 1;
        cyc();
        rst = 0;
        req0_valid = 1; req0_a = 10; req0_b = 3; req0_op = 3'd1;
        req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("t2_grant0", req0_ready, (k % 2) == 0);
            chk1("t2_grant1", req1_ready, (k % 2) == 1);
            cyc();
            if (k == 0) begin req0_a = 20; req0_b = 4; end
            if (k == 1) begin req1_a = 32'hFF; req1_b = 32'h3C; req1_op = 3'd2; end
            if (k == 3) begin req0_valid = 0; req1_valid = 0; end
            @(negedge clk);
            cyc();
            @(negedge clk);
            if (k % 2 == 0) chkw("t2_rsp0_c", rsp0_c, t2_exp[k]);
            else chkw("t2_rsp1_c", rsp1_c, t2_exp[k]);
            cyc();
        end

        // 3: rsp0 stalled for 5 cycles while req1 waits
        req0_valid = 1; req0_a = 32'hF0F0; req0_b = 32'hFF00; req0_op = 3'd2; rsp0_ready = 0;
        req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = 3'd0;
        @(negedge clk);
        chk1("t3_req0_ready", req0_ready, 1'b1);
        cyc();
        req0_valid = 0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1("t3_stall_v0", rsp0_valid, 1'b1);
            chkw("t3_stall_c0", rsp0_c, 32'hF000);
            chk1("t3_stall_r1", req1_ready, 1'b0);
            cyc();
        end
        rsp0_ready = 1;
        @(negedge clk);
        chk1("t3_r1_before_hs", req1_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk1("t3_r1_after_hs", req1_ready, 1'b1);
        cyc();
        req1_valid = 0;
        cyc();
        @(negedge clk);
        chkw("t3_rsp1_c", rsp1_c, 32'd3);
        cyc();

        // 4: async reset during EXEC drops the operation
        req1_valid = 1; req1_a = 32'h1234; req1_b = 1; req1_op = 3'd0;
        cyc();
        #1 rst = 1;
        #1;
        q0.delete();
        q1.delete();
        chk1("t4_busy", busy, 1'b0);
        chkw("t4_alu_a", alu_a, 32'd0);
        chkw("t4_alu_b", alu_b, 32'd0);
        chkw("t4_alu_op", 32'(alu_op), 32'd0);
        chk1("t4_req1_ready", req1_ready, 1'b0);
        cyc();
        rst = 0;
        req1_a = 32'hFF; req1_b = 32'h0F; req1_op = 3'd2;
        @(negedge clk);
        chk1("t4_rsp1_none", rsp1_valid, 1'b0);
        chk1("t4_req1_ready_new", req1_ready, 1'b1);
        cyc();
        req1_valid = 0;
        @(negedge clk);
        chk1("t4_no_stale_rsp", rsp1_valid | rsp0_valid, 1'b0);
        cyc();
        @(negedge clk);
        chkw("t4_rsp1_c", rsp1_c, 32'h0F);
        cyc();

        // 5: req0 arrives mid-RESP and beats continuously-valid req1
        req1_valid = 1; req1_a = 100; req1_b = 1; req1_op = 3'd0;
        @(negedge clk);
        chk1("t5_req1_first", req1_ready, 1'b1);
        cyc();
        cyc();
        req0_valid = 1; req0_a = 32'hAA; req0_b = 32'hFF; req0_op = 3'd4;
        @(negedge clk);
        chk1("t5_resp_r0", req0_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk1("t5_grant_r0", req0_ready, 1'b1);
        chk1("t5_hold_r1", req1_ready, 1'b0);
        cyc();
        req0_valid = 0;
        cyc();
        @(negedge clk);
        chkw("t5_rsp0_c", rsp0_c, 32'h55);
        cyc();
        @(negedge clk);
        chk1("t5_req1_next", req1_ready, 1'b1);
        cyc();
        req1_valid = 0;
        repeat (3) cyc();

        // 6: random traffic, results checked by the scoreboard
        ops = 0; ncyc = 0;
        while (ops < 1000 && ncyc < 20000) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            ops += int'(hs0) + int'(hs1);
            cyc();
            ncyc++;
            if (!req0_valid || hs0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
            end
            if (!req1_valid || hs1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
            end
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
        end
        chk1("t6_ops_done", ops >= 1000, 1'b1);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (10) cyc();
        chkw("t6_drain_q0", 32'(q0.size()), 32'd0);
        chkw("t6_drain_q1", 32'(q1.size()), 32'd0);
        chk1("t6_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
